// File: rtl/r_74148_pkg.sv
// r_74148 shared types and constants.
// Imported by every r_74148 file.
package r_74148_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int N_LINES = 8;
  localparam int CODE_W  = 3;

  localparam logic [CODE_W-1:0] NO_CODE_N = 3'b111;

endpackage

// File: rtl/r_74148_if.sv
// Offer/acknowledge handshake between the encoder and its consumer.
// The code and group select are held until ack_i is seen.
interface r_74148_if;
  import r_74148_pkg::*;

  logic              ack_i;
  logic [CODE_W-1:0] a_n_o;
  logic              gs_n_o;

  modport master (
    input  ack_i,
    output a_n_o,
    output gs_n_o
  );

  modport slave (
    output ack_i,
    input  a_n_o,
    input  gs_n_o
  );

endinterface

// File: rtl/r_74148_sync_ff.sv
// Multi-stage synchroniser for a bus of asynchronous lines.
// Resets to all ones so idle active-low lines read inactive.
module sync_ff #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] st [STAGES];

  // Shift the bus through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        st[i] <= '1;
      end
    end else begin
      st[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        st[i] <= st[i-1];
      end
    end
  end

  assign q = st[STAGES-1];

endmodule

// File: rtl/r_74148.sv
// Registered 8-to-3 priority encoder with latched falling-edge
// requests and a hold-until-acknowledged offer.
module r_74148
  import r_74148_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               ei_n_i,
  input  logic [N_LINES-1:0] d_n_i,
  r_74148_if.master          hs,
  output logic               eo_n_o,
  output logic [N_LINES-1:0] pending_o
);

  function automatic logic [CODE_W-1:0] prio(
    input logic [N_LINES-1:0] m
  );
    prio = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (m[i]) prio = CODE_W'(i);
    end
  endfunction

  logic [N_LINES-1:0] sync_q;
  logic [N_LINES-1:0] hist;
  logic [N_LINES-1:0] fall;
  logic [N_LINES-1:0] clr;
  logic [N_LINES-1:0] pend_nxt;
  logic [CODE_W-1:0]  off_idx;
  logic               take;
  logic               start;
  state_t             state;
  state_t             state_nxt;
  logic               eo_nxt;

  sync_ff #(
    .W      (N_LINES),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .d     (d_n_i),
    .q     (sync_q)
  );

  // Next pending mask, FSM transition and cascade output.
  always_comb begin
    fall      = hist & ~sync_q;
    off_idx   = ~hs.a_n_o;
    take      = (state == OFFER) && hs.ack_i;
    start     = (state == IDLE) && !ei_n_i
              && (pending_o != '0);
    clr       = '0;
    if (take) clr = N_LINES'(1) << off_idx;
    pend_nxt  = (pending_o & ~clr) | fall;
    state_nxt = state;
    unique case (1'b1)
      start:   state_nxt = OFFER;
      take:    state_nxt = IDLE;
      default: state_nxt = state;
    endcase
    eo_nxt = !(!ei_n_i && (state_nxt == IDLE)
             && (pend_nxt == '0));
  end

  // Edge history and pending request latch.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hist      <= '1;
      pending_o <= '0;
    end else begin
      hist      <= sync_q;
      pending_o <= pend_nxt;
    end
  end

  // Offer FSM with registered code and group select.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      hs.a_n_o  <= NO_CODE_N;
      hs.gs_n_o <= 1'b1;
      eo_n_o    <= 1'b1;
    end else begin
      state  <= state_nxt;
      eo_n_o <= eo_nxt;
      if (start) begin
        hs.a_n_o  <= ~prio(pending_o);
        hs.gs_n_o <= 1'b0;
      end else if (take) begin
        hs.a_n_o  <= NO_CODE_N;
        hs.gs_n_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_r_74148.sv
// Testbench for r_74148: directed scenarios plus random
// traffic checked against a behavioural model.
module tb_r_74148;

  localparam int SYNC = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ei_n  = 1'b0;
  logic       ack   = 1'b0;
  logic [7:0] d_n   = 8'hFF;
  logic       eo_n;
  logic [7:0] pending;

  int n_cmp = 0;
  int n_err = 0;

  r_74148_if hs ();
  assign hs.ack_i = ack;

  r_74148 #(
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .ei_n_i    (ei_n),
    .d_n_i     (d_n),
    .hs        (hs),
    .eo_n_o    (eo_n),
    .pending_o (pending)
  );

  always #5 clk = ~clk;

  // dh[0] is the newest sampled value of d_n
  bit [7:0] dh [SYNC+2];
  bit [7:0] m_pend;
  bit       m_off;
  int       m_code;
  bit       m_eo;

  task automatic check(input string tag, input int got,
                       input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC + 2; i++) dh[i] = 8'hFF;
    m_pend = '0;
    m_off  = 1'b0;
    m_code = 0;
    m_eo   = 1'b1;
  endtask

  // One rising edge: a line's fall seen through the
  // synchroniser becomes a request SYNC edges later.
  task automatic model_edge();
    bit [7:0] newb;
    for (int i = SYNC + 1; i > 0; i--) dh[i] = dh[i-1];
    dh[0] = d_n;
    newb = ~dh[SYNC] & dh[SYNC+1];
    if (m_off) begin
      if (ack) begin
        m_pend[m_code] = 1'b0;
        m_off = 1'b0;
      end
    end else if (!ei_n && m_pend != 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (m_pend[i]) begin
          m_code = i;
          break;
        end
      end
      m_off = 1'b1;
    end
    m_pend = m_pend | newb;
    m_eo = !(!ei_n && !m_off && m_pend == 0);
  endtask

  task automatic check_all();
    check("pending", int'(pending), int'(m_pend));
    check("gs_n", int'(hs.gs_n_o), int'(!m_off));
    check("a_n", int'(hs.a_n_o), m_off ? 7 - m_code : 7);
    check("eo_n", int'(eo_n), int'(m_eo));
  endtask

  task automatic step(input logic [7:0] d, input logic e,
                      input logic a);
    d_n  = d;
    ei_n = e;
    ack  = a;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [7:0] d;
    model_reset();
    @(negedge clk);
    check("rst_gs", int'(hs.gs_n_o), 1);
    check("rst_a", int'(hs.a_n_o), 7);
    check("rst_pend", int'(pending), 0);
    check("rst_eo", int'(eo_n), 1);
    rst_n = 1'b1;
    step(8'hFF, 1'b0, 1'b0);
    check("eo_first", int'(eo_n), 0);

    // line 5: offer exactly four edges after the fall
    for (int i = 0; i < 3; i++) step(8'hDF, 1'b0, 1'b0);
    check("l5_early", int'(hs.gs_n_o), 1);
    step(8'hDF, 1'b0, 1'b0);
    check("l5_gs", int'(hs.gs_n_o), 0);
    check("l5_a", int'(hs.a_n_o), 3'b010);
    for (int i = 0; i < 10; i++) step(8'hDF, 1'b0, 1'b0);
    check("l5_hold", int'(hs.a_n_o), 3'b010);
    step(8'hDF, 1'b0, 1'b1);
    check("l5_ack_pend", int'(pending), 0);
    check("l5_ack_gs", int'(hs.gs_n_o), 1);
    step(8'hFF, 1'b0, 1'b0);

    // lines 2 and 6 together, then 7 during offer of 2
    for (int i = 0; i < 4; i++) step(8'hBB, 1'b0, 1'b0);
    check("l6_a", int'(hs.a_n_o), 3'b001);
    step(8'hBB, 1'b0, 1'b1);
    step(8'hBB, 1'b0, 1'b0);
    check("l2_a", int'(hs.a_n_o), 3'b101);
    for (int i = 0; i < 3; i++) step(8'h3B, 1'b0, 1'b0);
    check("l2_kept", int'(hs.a_n_o), 3'b101);
    step(8'h3B, 1'b0, 1'b1);
    step(8'h3B, 1'b0, 1'b0);
    check("l7_a", int'(hs.a_n_o), 3'b000);
    step(8'hFF, 1'b0, 1'b1);

    // disabled encoder still captures line 3
    for (int i = 0; i < 4; i++) step(8'hF7, 1'b1, 1'b0);
    check("ei_pend", int'(pending), 8'h08);
    check("ei_gs", int'(hs.gs_n_o), 1);
    check("ei_eo", int'(eo_n), 1);
    step(8'hF7, 1'b0, 1'b0);
    check("l3_a", int'(hs.a_n_o), 3'b100);
    step(8'hF7, 1'b0, 1'b1);

    // line 4 held low through its ack
    for (int i = 0; i < 4; i++) step(8'hEF, 1'b0, 1'b0);
    check("l4_a", int'(hs.a_n_o), 3'b011);
    step(8'hEF, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(8'hEF, 1'b0, 1'b0);
    check("l4_held", int'(pending), 0);
    step(8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(8'hEF, 1'b0, 1'b0);
    // new fall lands on the same edge as the ack
    step(8'hFF, 1'b0, 1'b0);
    step(8'hEF, 1'b0, 1'b0);
    step(8'hEF, 1'b0, 1'b0);
    step(8'hEF, 1'b0, 1'b1);
    check("l4_setwins", int'(pending), 8'h10);
    step(8'hEF, 1'b0, 1'b0);
    check("l4_reoffer", int'(hs.a_n_o), 3'b011);

    // asynchronous reset in the middle of an offer
    #2 rst_n = 1'b0;
    #1;
    check("arst_gs", int'(hs.gs_n_o), 1);
    check("arst_a", int'(hs.a_n_o), 7);
    check("arst_pend", int'(pending), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    d = 8'hFF;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) d[b] = ~d[b];
      end
      step(d, ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
